// File: rtl/apb_initiator_package.sv
`default_nettype none
// ============================================================================
// apb_initiator_package: shared types and constants for the APB register
// initiator and its register completers.
// Revision: 1.0
// ============================================================================
package apb_initiator_package;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Also returned by the register completers for unmapped reads
    localparam logic [31:0] APB_ERR_PATTERN = 32'hBADD_C0DE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apbReqSt;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apbRspSt;

endpackage
`default_nettype wire

// File: rtl/apb_reg_initiator.sv
`default_nettype none
// ============================================================================
// apb_reg_initiator: runs one APB setup/access transfer per request-channel
// command and returns read data and error status on a response channel.
// Revision: 1.0
// ============================================================================
module apb_reg_initiator
    import apb_initiator_package::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int                  c_CW        = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CW-1:0]     c_WAIT_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] c_ERR_DATA = DATA_WIDTH'(APB_ERR_PATTERN);

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("apb_reg_initiator: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    apb_state_e              r_state;
    logic [c_CW-1:0]         r_wait_cnt;
    logic                    r_req_ready;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_rsp_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_wait_cnt    <= '0;
            r_req_ready   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        // Misaligned commands are answered locally; the bus stays quiet
                        if (req_addr[1:0] != 2'b00) begin
                            r_state       <= RESP;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_rdata   <= c_ERR_DATA;
                            r_rsp_err     <= 1'b1;
                            r_rsp_timeout <= 1'b0;
                        end else begin
                            r_state    <= SETUP;
                            r_psel     <= 1'b1;
                            r_pwrite   <= req_write;
                            r_paddr    <= req_addr;
                            r_pwdata   <= req_wdata;
                            r_wait_cnt <= '0;
                        end
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        r_state       <= RESP;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_pwrite      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                        r_rsp_err     <= pslverr;
                        r_rsp_timeout <= 1'b0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state       <= RESP;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_pwrite      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= c_ERR_DATA;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_initiator.sv
`default_nettype none
// ============================================================================
// tb_apb_reg_initiator: directed vectors against a small APB register model
// (rw register at 0x0, read-only 0x5 at 0x8, everything else errors).
// Revision: 1.0
// ============================================================================
module tb_apb_reg_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_reg_initiator #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    // Completer model: answers after ws wait states; ws large means never
    int          ws      = 0;
    logic        late    = 1'b0;
    int          acc_cnt = 0;
    int          n_psel  = 0;
    int          n_pen   = 0;
    logic [31:0] reg0    = '0;

    always @(negedge clk) begin
        if (psel) n_psel++;
        if (penable) begin
            n_pen++;
            total++;
            if (!psel) begin
                bad++;
                $display("FAIL penable_without_psel: psel=%0b required 1", psel);
            end
        end
        if (psel && penable && !late) begin
            if (acc_cnt == ws) begin
                pready = 1'b1;
                case (paddr)
                    32'h0: begin
                        pslverr = 1'b0;
                        prdata  = pwrite ? 32'h0 : reg0;
                        if (pwrite) reg0 = pwdata;
                    end
                    32'h8: begin
                        pslverr = pwrite;
                        prdata  = 32'h5;
                    end
                    default: begin
                        pslverr = 1'b1;
                        prdata  = 32'hBADD_C0DE;
                    end
                endcase
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = 32'h0;
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = late;
            pslverr = late;
            prdata  = late ? 32'h1111_1111 : 32'h0;
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ws;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;
        int          exp_psel;
        int          exp_pen;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic wr, logic [31:0] addr, logic [31:0] wdata, int w,
                                logic [31:0] rd, logic err, logic to,
                                int lat, int np, int ne);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.ws = w;
        v.exp_rdata = rd; v.exp_err = err; v.exp_to = to;
        v.exp_lat = lat; v.exp_psel = np; v.exp_pen = ne;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after an edge with the DUT idle; returns #1 into cycle 1
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int p0;
        int e0;
        string tag;
        tag = $sformatf("v%0d", idx);
        ws = v.ws;
        p0 = n_psel;
        e0 = n_pen;
        issue(v.wr, v.addr, v.wdata);
        wait_rsp(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
        chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
        step();
        chk({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
        chk({tag, "_rdata_hold"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_psel_cycles"}, 32'(n_psel - p0), 32'(v.exp_psel));
        chk({tag, "_penable_cycles"}, 32'(n_pen - e0), 32'(v.exp_pen));
    endtask

    initial begin
        int lat;
        int e0;

        vecs[0]  = mk(1'b1, 32'h0, 32'h0000_007F, 0,   32'h0,         1'b0, 1'b0, 3,  2,  1);
        vecs[1]  = mk(1'b0, 32'h0, 32'h0,         0,   32'h0000_007F, 1'b0, 1'b0, 3,  2,  1);
        vecs[2]  = mk(1'b0, 32'h4, 32'h0,         0,   32'hBADD_C0DE, 1'b1, 1'b0, 3,  2,  1);
        vecs[3]  = mk(1'b0, 32'h8, 32'h0,         1,   32'h5,         1'b0, 1'b0, 4,  3,  2);
        vecs[4]  = mk(1'b1, 32'h0, 32'h1234_5678, 2,   32'h0,         1'b0, 1'b0, 5,  4,  3);
        vecs[5]  = mk(1'b0, 32'h0, 32'h0,         0,   32'h1234_5678, 1'b0, 1'b0, 3,  2,  1);
        vecs[6]  = mk(1'b1, 32'h2, 32'hFFFF_FFFF, 0,   32'hBADD_C0DE, 1'b1, 1'b0, 1,  0,  0);
        vecs[7]  = mk(1'b0, 32'h1, 32'h0,         0,   32'hBADD_C0DE, 1'b1, 1'b0, 1,  0,  0);
        vecs[8]  = mk(1'b0, 32'h0, 32'h0,         255, 32'hBADD_C0DE, 1'b1, 1'b1, 18, 17, 16);
        vecs[9]  = mk(1'b0, 32'h0, 32'h0,         15,  32'h1234_5678, 1'b0, 1'b0, 18, 17, 16);
        vecs[10] = mk(1'b1, 32'h8, 32'hAAAA_5555, 0,   32'h0,         1'b1, 1'b0, 3,  2,  1);
        vecs[11] = mk(1'b0, 32'h0, 32'h0,         0,   32'h1234_5678, 1'b0, 1'b0, 3,  2,  1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_psel", 32'(psel), 32'd0);
        chk("reset_penable", 32'(penable), 32'd0);
        chk("reset_pwrite", 32'(pwrite), 32'd0);
        chk("reset_paddr", paddr, 32'h0);
        chk("reset_pwdata", pwdata, 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_flags", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Misaligned write stalled by the consumer for 5 cycles
        rsp_ready = 1'b0;
        issue(1'b1, 32'h2, 32'h0000_0001);
        chk("stall_rsp_valid_cycle1", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_rdata", rsp_rdata, 32'hBADD_C0DE);
            chk("stall_rsp_err", 32'(rsp_err), 32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_psel", 32'(psel), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("stall_release_req_ready", 32'(req_ready), 32'd1);

        // Timeout followed by a late pready while the response is held
        ws = 255;
        rsp_ready = 1'b0;
        e0 = n_pen;
        issue(1'b0, 32'h0, 32'h0);
        wait_rsp(lat);
        chk("late_latency", 32'(lat), 32'd18);
        chk("late_penable_cycles", 32'(n_pen - e0), 32'd16);
        late = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("late_psel", 32'(psel), 32'd0);
            chk("late_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("late_rsp_timeout", 32'(rsp_timeout), 32'd1);
            chk("late_rsp_rdata", rsp_rdata, 32'hBADD_C0DE);
        end
        late = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("late_release_req_ready", 32'(req_ready), 32'd1);
        step();

        // Reset in the middle of a stalled ACCESS
        ws = 255;
        issue(1'b0, 32'h8, 32'h0);
        repeat (4) step();
        chk("midrst_penable_before", 32'(penable), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_psel", 32'(psel), 32'd0);
        chk("midrst_penable", 32'(penable), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        run_vec(mk(1'b0, 32'h8, 32'h0, 0, 32'h5, 1'b0, 1'b0, 3, 2, 1), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
